// File: rtl/sdn_parser_header_extractor.sv
// rtl/sdn_parser_header_extractor.sv - captures a 64-byte header window and serves byte-field extract commands
// Optional statistics counters: define SDN_PARSER_HDR_EXTRACT_STAT_EN
module sdn_parser_header_extractor #(
  parameter int DATA_W    = 64,
  parameter int HDR_WORDS = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] pkt_data,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic              pkt_sop,
  input  logic              pkt_eop,
  input  logic [2:0]        pkt_mod,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_offset,
  input  logic [3:0]        cmd_len,
  input  logic              cmd_last,
  output logic              fld_valid,
  input  logic              fld_ready,
  output logic [DATA_W-1:0] fld_data,
  output logic              fld_err,
  output logic              fld_last,
  output logic [6:0]        hdr_bytes
`ifdef SDN_PARSER_HDR_EXTRACT_STAT_EN
  ,
  output logic [31:0]       stat_pkt_cnt,
  output logic [31:0]       stat_err_cnt
`endif
);

  localparam int WIN_W = HDR_WORDS * DATA_W;
  localparam int CNT_W = $clog2(HDR_WORDS + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, EXTRACT, DRAIN} state_t;

  state_t             state;
  logic [WIN_W-1:0]   win;
  logic [CNT_W-1:0]   wcnt;
  logic               eop_seen;
  logic               pkt_fire;
  logic               cmd_fire;
  logic [3:0]         word_bytes;
  logic [7:0]         bytes_sum;
  logic [6:0]         bytes_next;
  logic [6:0]         cmd_end;
  logic [8:0]         sh_off;
  logic [6:0]         sh_len;
  logic [WIN_W-1:0]   win_shl;
  logic [DATA_W-1:0]  fld_calc;
  logic               cmd_bad;

  assign pkt_fire  = pkt_valid && pkt_ready;
  assign cmd_ready = (state == EXTRACT) && (!fld_valid || fld_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_comb begin
    word_bytes = 4'd8;
    if (pkt_eop && (pkt_mod != 3'd0)) word_bytes = {1'b0, pkt_mod};
    bytes_sum  = {1'b0, hdr_bytes} + {4'b0000, word_bytes};
    bytes_next = (bytes_sum > 8'd64) ? 7'd64 : bytes_sum[6:0];
  end

  // Byte 0 of the window sits at the MSB; shift the requested bytes to the top, then right-align.
  always_comb begin
    cmd_end  = {1'b0, cmd_offset} + {3'b000, cmd_len};
    cmd_bad  = (cmd_len == 4'd0) || (cmd_len > 4'd8) || (cmd_end > hdr_bytes);
    sh_off   = {cmd_offset, 3'b000};
    sh_len   = {(4'd8 - cmd_len), 3'b000};
    win_shl  = win << sh_off;
    fld_calc = win_shl[WIN_W-1 -: DATA_W] >> sh_len;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      win       <= '0;
      wcnt      <= '0;
      eop_seen  <= 1'b0;
      pkt_ready <= 1'b0;
      fld_valid <= 1'b0;
      fld_data  <= '0;
      fld_err   <= 1'b0;
      fld_last  <= 1'b0;
      hdr_bytes <= '0;
`ifdef SDN_PARSER_HDR_EXTRACT_STAT_EN
      stat_pkt_cnt <= '0;
      stat_err_cnt <= '0;
`endif
    end else begin
      if (cmd_fire) begin
        fld_valid <= 1'b1;
        fld_err   <= cmd_bad;
        fld_data  <= cmd_bad ? '0 : fld_calc;
        fld_last  <= cmd_last;
`ifdef SDN_PARSER_HDR_EXTRACT_STAT_EN
        if (cmd_bad && (stat_err_cnt != 32'hFFFF_FFFF)) stat_err_cnt <= stat_err_cnt + 32'd1;
`endif
      end else if (fld_ready) begin
        fld_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          pkt_ready <= 1'b1;
          if (pkt_fire && pkt_sop) begin
            win[WIN_W-1 -: DATA_W] <= pkt_data;
            wcnt      <= CNT_W'(1);
            hdr_bytes <= {3'b000, word_bytes};
            eop_seen  <= pkt_eop;
`ifdef SDN_PARSER_HDR_EXTRACT_STAT_EN
            if (stat_pkt_cnt != 32'hFFFF_FFFF) stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
`endif
            if (pkt_eop) begin
              state     <= EXTRACT;
              pkt_ready <= 1'b0;
            end else begin
              state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (pkt_fire) begin
            for (int i = 1; i < HDR_WORDS; i++) begin
              if (wcnt == i[CNT_W-1:0]) win[(HDR_WORDS-1-i)*DATA_W +: DATA_W] <= pkt_data;
            end
            wcnt      <= wcnt + CNT_W'(1);
            hdr_bytes <= bytes_next;
            eop_seen  <= pkt_eop;
            if (pkt_eop || (wcnt == CNT_W'(HDR_WORDS - 1))) begin
              state     <= EXTRACT;
              pkt_ready <= 1'b0;
            end
          end
        end
        EXTRACT: begin
          if (cmd_fire && cmd_last) begin
            state     <= eop_seen ? IDLE : DRAIN;
            pkt_ready <= 1'b1;
          end
        end
        DRAIN: begin
          pkt_ready <= 1'b1;
          if (pkt_fire && pkt_eop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdn_parser_header_extractor.sv
// tb/tb_sdn_parser_header_extractor.sv - randomized bench for sdn_parser_header_extractor against a byte-array model
module tb_sdn_parser_header_extractor;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] pkt_data = '0;
  logic        pkt_valid = 1'b0, pkt_sop = 1'b0, pkt_eop = 1'b0;
  logic [2:0]  pkt_mod = '0;
  logic        pkt_ready;
  logic        cmd_valid = 1'b0, cmd_last = 1'b0;
  logic [5:0]  cmd_offset = '0;
  logic [3:0]  cmd_len = '0;
  logic        cmd_ready;
  logic        fld_valid, fld_err, fld_last;
  logic        fld_ready = 1'b1;
  logic [63:0] fld_data;
  logic [6:0]  hdr_bytes;
`ifdef SDN_PARSER_HDR_EXTRACT_STAT_EN
  logic [31:0] stat_pkt_cnt, stat_err_cnt;
`endif

  sdn_parser_header_extractor #(.DATA_W(64), .HDR_WORDS(8)) dut (
    .clk(clk), .rstn(rstn),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_mod(pkt_mod),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_offset(cmd_offset),
    .cmd_len(cmd_len), .cmd_last(cmd_last),
    .fld_valid(fld_valid), .fld_ready(fld_ready), .fld_data(fld_data),
    .fld_err(fld_err), .fld_last(fld_last), .hdr_bytes(hdr_bytes)
`ifdef SDN_PARSER_HDR_EXTRACT_STAT_EN
    , .stat_pkt_cnt(stat_pkt_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0]  pb [64];
  int          hdr_exp = 0;
  int          rem = 0;
  logic [63:0] word0;
  bit          fr_auto = 1'b0;
  int          n_acc = 0, n_del = 0;
  int          tb_pkts = 0, tb_errs = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_field(input int off, input int len);
    logic [63:0] v = '0;
    for (int k = 0; k < len; k++) v = (v << 8) | {56'd0, pb[off+k]};
    return v;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (fr_auto) fld_ready = ($urandom_range(0, 3) != 0);
  end

  // Output-side monitor: latency-1 load, hold while stalled, handshake counting.
  logic [63:0] exp_d, hold_d;
  logic        exp_e, exp_l;
  bit          pend = 1'b0, hold_chk = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      pend = 1'b0;
      hold_chk = 1'b0;
    end else begin
      if (pend) begin
        check_eq("fld_valid_lat1", fld_valid, 1);
        check_eq("fld_data", fld_data, exp_d);
        check_eq("fld_err", fld_err, exp_e);
        check_eq("fld_last", fld_last, exp_l);
        pend = 1'b0;
      end else if (hold_chk) begin
        check_eq("hold_valid", fld_valid, 1);
        check_eq("hold_data", fld_data, hold_d);
      end
      hold_chk = 1'b0;
      if (fld_valid && !fld_ready) begin
        hold_chk = 1'b1;
        hold_d = fld_data;
        check_eq("cmd_ready_stall", cmd_ready, 0);
      end
      if (fld_valid && fld_ready) n_del++;
      if (cmd_valid && cmd_ready) begin
        int off, len;
        off = int'(cmd_offset);
        len = int'(cmd_len);
        exp_e = (len == 0) || (len > 8) || (off + len > hdr_exp);
        exp_d = exp_e ? 64'd0 : model_field(off, len);
        exp_l = cmd_last;
        if (exp_e) tb_errs++;
        pend = 1'b1;
        n_acc++;
      end
    end
  end

  task automatic send_word(input logic [63:0] d, input logic sop, input logic eop, input logic [2:0] mod);
    int t = 0;
    pkt_data = d; pkt_sop = sop; pkt_eop = eop; pkt_mod = mod; pkt_valid = 1'b1;
    do begin @(negedge clk); t++; end while (!pkt_ready && t < 1000);
    check_eq("pkt_accept", pkt_ready, 1);
    @(posedge clk); #1;
    pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
  endtask

  task automatic send_cmd(input int off, input int len, input logic last, output int acc_cyc);
    int t = 0;
    cmd_offset = off[5:0]; cmd_len = len[3:0]; cmd_last = last; cmd_valid = 1'b1;
    do begin @(negedge clk); t++; end while (!cmd_ready && t < 1000);
    check_eq("cmd_accept", cmd_ready, 1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic capture_packet(input int n, input int mod);
    int cap, tot, bw;
    logic [63:0] d;
    cap = (n < 8) ? n : 8;
    tot = 0;
    for (int w = 0; w < cap; w++) begin
      d = {$urandom, $urandom};
      if (w == 0) word0 = d;
      for (int j = 0; j < 8; j++) pb[w*8+j] = d[63-8*j -: 8];
      bw = ((w == n-1) && (mod != 0)) ? mod : 8;
      tot += bw;
      send_word(d, w == 0, w == n-1, 3'(mod));
      check_eq("hdr_bytes_word", 64'(hdr_bytes), 64'((tot > 64) ? 64 : tot));
    end
    hdr_exp = (tot > 64) ? 64 : tot;
    rem = n - cap;
    tb_pkts++;
    check_eq("pkt_ready_extract", pkt_ready, 0);
  endtask

  task automatic drain_packet();
    for (int r = 0; r < rem; r++) begin
      send_word({$urandom, $urandom}, 1'($urandom_range(0, 1)), r == rem-1, 3'd0);
      check_eq("hdr_bytes_drain", 64'(hdr_bytes), 64'(hdr_exp));
    end
    rem = 0;
  endtask

  task automatic random_cmds(input int ncmd);
    int off, len, c;
    for (int i = 0; i < ncmd; i++) begin
      off = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, hdr_exp - 1);
      len = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8);
      send_cmd(off, len, i == ncmd-1, c);
    end
    check_eq("pkt_ready_after_last", pkt_ready, 1);
    check_eq("cmd_ready_after_last", cmd_ready, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, c3;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pkt_ready", pkt_ready, 0);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_fld_valid", fld_valid, 0);
    check_eq("rst_fld_err", fld_err, 0);
    check_eq("rst_fld_last", fld_last, 0);
    check_eq("rst_fld_data", fld_data, 0);
    check_eq("rst_hdr_bytes", 64'(hdr_bytes), 0);
    rstn = 1'b1;

    // 3-word packet, 4 valid bytes in the last word
    capture_packet(3, 4);
    check_eq("hdr_20", 64'(hdr_bytes), 20);
    send_cmd(12, 2, 1'b0, c0);
    check_eq("f12_2_data", fld_data, {48'd0, pb[12], pb[13]});
    check_eq("f12_2_err", fld_err, 0);
    send_cmd(18, 4, 1'b0, c0);
    check_eq("f18_4_err", fld_err, 1);
    check_eq("f18_4_data", fld_data, 0);
    send_cmd(0, 8, 1'b1, c0);
    check_eq("word0_exact", fld_data, word0);
    check_eq("pkt_ready_idle", pkt_ready, 1);

    // 12-word packet: window fills at 8, first command is last, rest drained
    capture_packet(12, 0);
    check_eq("hdr_64", 64'(hdr_bytes), 64);
    send_cmd(56, 8, 1'b1, c0);
    check_eq("pkt_ready_drain", pkt_ready, 1);
    drain_packet();
    capture_packet(2, 0);
    random_cmds(2);

    // output stall, then three back-to-back fields
    fr_auto = 1'b0;
    fld_ready = 1'b1;
    capture_packet(8, 0);
    fld_ready = 1'b0;
    send_cmd(0, 8, 1'b0, c0);
    cmd_offset = 6'd8; cmd_len = 4'd8; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_cmd_ready", cmd_ready, 0);
      check_eq("stall_data", fld_data, word0);
    end
    @(posedge clk); #1;
    fld_ready = 1'b1;
    send_cmd(8, 8, 1'b0, c1);
    send_cmd(16, 4, 1'b0, c2);
    send_cmd(20, 2, 1'b1, c3);
    check_eq("b2b_1", 64'(c2 - c1), 1);
    check_eq("b2b_2", 64'(c3 - c2), 1);
    repeat (2) @(posedge clk);
    #1;

    // reset in the middle of capture
    send_word({$urandom, $urandom}, 1'b1, 1'b0, 3'd0);
    send_word({$urandom, $urandom}, 1'b0, 1'b0, 3'd0);
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_pkt_ready", pkt_ready, 0);
    check_eq("arst_cmd_ready", cmd_ready, 0);
    check_eq("arst_fld_valid", fld_valid, 0);
    check_eq("arst_fld_data", fld_data, 0);
    check_eq("arst_hdr_bytes", 64'(hdr_bytes), 0);
    n_acc = 0; n_del = 0; tb_pkts = 0; tb_errs = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_word({$urandom, $urandom}, 1'b0, i == 2, 3'd0);
      check_eq("nosop_hdr", 64'(hdr_bytes), 0);
      check_eq("nosop_ready", pkt_ready, 1);
    end
    capture_packet(5, 3);
    random_cmds(3);

    // randomized packets and commands
    fr_auto = 1'b1;
    for (int p = 0; p < 25; p++) begin
      capture_packet($urandom_range(1, 12), $urandom_range(0, 7));
      random_cmds($urandom_range(1, 5));
      drain_packet();
    end

    fr_auto = 1'b0;
    #2;
    fld_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("fields_delivered", 64'(n_del), 64'(n_acc));
`ifdef SDN_PARSER_HDR_EXTRACT_STAT_EN
    check_eq("stat_pkt_cnt", 64'(stat_pkt_cnt), 64'(tb_pkts));
    check_eq("stat_err_cnt", 64'(stat_err_cnt), 64'(tb_errs));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
